alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 26 ++
 rtl/alu_arbiter_alu.sv | 36 +++
 rtl/alu_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the CPU datapath and the ALU arbiter.
//   DATA_WIDTH       - default operand/result width
//   ALUCONTROL_WIDTH - default ALU control code width
//   ALU_*            - ALU control codes
//   ST_*             - arbiter FSM state encodings
//   port_onehot()    - maps a port index (0 = A, 1 = B) to a one-hot pair
package alu_arbiter_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int ALUCONTROL_WIDTH = 4;

  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SLL = 4'b1000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU with signed operands.
//   src1, src2 : operands (signed)
//   ctrl       : ALU control code
//   y          : result; unknown codes give 0, add/sub wrap
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH  = DATA_WIDTH,
  parameter int CTRL_W = ALUCONTROL_WIDTH
) (
  input  logic signed [WIDTH-1:0]  src1,
  input  logic signed [WIDTH-1:0]  src2,
  input  logic        [CTRL_W-1:0] ctrl,
  output logic signed [WIDTH-1:0]  y
);

  logic signed [WIDTH-1:0] diff;

  // set-less-than looks at the sign of the wrapped difference
  assign diff = src1 - src2;

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_ADD: y = src1 + src2;
      ALU_SUB: y = diff;
      ALU_AND: y = src1 & src2;
      ALU_OR:  y = src1 | src2;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, diff[WIDTH-1]};
      // shift amount is the full src1 value; large amounts give 0
      ALU_SLL: y = src2 << $unsigned(src1);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing a single ALU between requesters A and B.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   req_valid_i/req_ready_o : per-port request handshake (bit 0 = A, 1 = B)
//   src1_*_i, src2_*_i      : per-port operands
//   ctrl_*_i                : per-port ALU control code
//   resp_valid_o            : one-hot result valid to the owning port
//   resp_ready_i            : per-port result accept (non-owner ignored)
//   result_o                : registered ALU result shared by both ports
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH  = DATA_WIDTH,
  parameter int CTRL_W = ALUCONTROL_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [WIDTH-1:0]  src1_a_i,
  input  logic [WIDTH-1:0]  src2_a_i,
  input  logic [WIDTH-1:0]  src1_b_i,
  input  logic [WIDTH-1:0]  src2_b_i,
  input  logic [CTRL_W-1:0] ctrl_a_i,
  input  logic [CTRL_W-1:0] ctrl_b_i,
  output logic [1:0]        resp_valid_o,
  input  logic [1:0]        resp_ready_i,
  output logic [WIDTH-1:0]  result_o
);

  logic [0:0]              state_p1;
  logic                    owner_p1;
  logic                    rr_p1;
  logic [WIDTH-1:0]        result_p1;

  logic                    grant;
  logic                    resp_xfer;
  logic                    slot_free;
  logic                    req_xfer;
  logic signed [WIDTH-1:0] alu_src1;
  logic signed [WIDTH-1:0] alu_src2;
  logic        [CTRL_W-1:0] alu_ctrl;
  logic signed [WIDTH-1:0] alu_y;

  // ---- stage 0: grant, handshake and operand mux ----
  always_comb begin
    grant     = (req_valid_i == 2'b11) ? rr_p1 : req_valid_i[1];
    resp_xfer = (state_p1 == ST_HOLD) && resp_ready_i[owner_p1];
    // a held result leaving this cycle frees the slot for a new request
    slot_free = (state_p1 == ST_IDLE) || resp_xfer;
    req_xfer  = rst_n_i && slot_free && (|req_valid_i);
    req_ready_o = req_xfer ? port_onehot(grant) : 2'b00;

    alu_src1 = grant ? $signed(src1_b_i) : $signed(src1_a_i);
    alu_src2 = grant ? $signed(src2_b_i) : $signed(src2_a_i);
    alu_ctrl = grant ? ctrl_b_i : ctrl_a_i;
  end

  alu_arbiter_alu #(
    .WIDTH (WIDTH),
    .CTRL_W(CTRL_W)
  ) u_alu (
    .src1(alu_src1),
    .src2(alu_src2),
    .ctrl(alu_ctrl),
    .y   (alu_y)
  );

  // ---- stage 1: held result, owner and round-robin pointer ----
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_p1  <= ST_IDLE;
      owner_p1  <= 1'b0;
      rr_p1     <= 1'b0;
      result_p1 <= '0;
    end else if (req_xfer) begin
      state_p1  <= ST_HOLD;
      owner_p1  <= grant;
      rr_p1     <= ~grant;
      result_p1 <= alu_y;
    end else if (resp_xfer) begin
      state_p1  <= ST_IDLE;
    end
  end

  assign resp_valid_o = (state_p1 == ST_HOLD) ? port_onehot(owner_p1) : 2'b00;
  assign result_o     = result_p1;

endmodule
